usb_stream_trace: RTL and testbench

USB_STREAM_TRACE -- requirements
Module: usb_stream_trace

---
 rtl/usb_trace_pkg.sv | 36 +++
 rtl/usb_trace_ram.sv | 38 +++
 rtl/usb_stream_trace.sv | 175 +++++++++++++++++
 tb/tb_usb_stream_trace.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_trace_pkg.sv
// Shared definitions for the stream trace: capture state encoding and entry layout.
// An entry is {timestamp, slot[CHANNELS-1], ..., slot[0]}, each slot being {beat, tlast, tdata}.
package usb_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_TRIG  = 2'd2,
        ST_DONE  = 2'd3
    } trace_state_e;

    // Offsets inside one channel slot, counted from the slot LSB.
    localparam int SLOT_CTRL_W   = 2;
    localparam int SLOT_DATA_OFS = 0;

    function automatic int slot_w(input int dw);
        return dw + SLOT_CTRL_W;
    endfunction

    function automatic int slot_last_ofs(input int dw);
        return dw;
    endfunction

    function automatic int slot_beat_ofs(input int dw);
        return dw + 1;
    endfunction

    function automatic int ts_lsb(input int channels, input int dw);
        return channels * slot_w(dw);
    endfunction

    function automatic int entry_w(input int ts_w, input int channels, input int dw);
        return ts_w + ts_lsb(channels, dw);
    endfunction

endpackage

// File: rtl/usb_trace_ram.sv
// Trace storage: simple dual-port RAM, one write port and one registered read-first read port.
// Latency: rd_data valid one cycle after rd_en; holds while rd_en is low.
// Backpressure: none, both ports accept every cycle.
module usb_trace_ram #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 36
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Only the output register is reset; a same-address write lands after this read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/usb_stream_trace.sv
// Multi-channel AXI-stream beat tracer with trigger, post-trigger count and readback port.
// Latency: an entry is written in the cycle of its beat; readback is one cycle after rd_en.
// Backpressure: passive monitor, never stalls the streams; only completed handshakes are logged.
module usb_stream_trace
    import usb_trace_pkg::*;
#(
    parameter int CHANNELS   = 2,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 1024,
    parameter int TS_WIDTH   = 16
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic [CHANNELS-1:0]                        mon_tvalid,
    input  logic [CHANNELS-1:0]                        mon_tready,
    input  logic [CHANNELS-1:0]                        mon_tlast,
    input  logic [CHANNELS*DATA_WIDTH-1:0]             mon_tdata,
    input  logic                                       arm,
    input  logic                                       stop,
    input  logic [CHANNELS-1:0]                        trig_mask,
    input  logic [$clog2(DEPTH)-1:0]                   post_count,
    input  logic                                       rd_en,
    input  logic [$clog2(DEPTH)-1:0]                   rd_addr,
    output logic [entry_w(TS_WIDTH, CHANNELS, DATA_WIDTH)-1:0] rd_data,
    output logic [1:0]                                 state,
    output logic [$clog2(DEPTH)-1:0]                   wr_ptr,
    output logic [$clog2(DEPTH)-1:0]                   trig_ptr,
    output logic [$clog2(DEPTH):0]                     entries
);

    localparam int AW       = $clog2(DEPTH);
    localparam int EW       = entry_w(TS_WIDTH, CHANNELS, DATA_WIDTH);
    localparam int SW       = slot_w(DATA_WIDTH);
    localparam int TSL      = ts_lsb(CHANNELS, DATA_WIDTH);
    localparam int LAST_OFS = slot_last_ofs(DATA_WIDTH);
    localparam int BEAT_OFS = slot_beat_ofs(DATA_WIDTH);
    localparam logic [AW:0] ENT_MAX = (AW+1)'(DEPTH);

    trace_state_e      state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     trig_ptr_q, trig_ptr_d;
    logic [AW-1:0]     post_lat_q, post_lat_d;
    logic [AW-1:0]     post_rem_q, post_rem_d;
    logic [AW:0]       entries_q, entries_d;
    logic [TS_WIDTH-1:0] ts_q, ts_d;

    logic [CHANNELS-1:0] beat;
    logic                wr_en;
    logic                trig_fire;
    logic [EW-1:0]       wr_entry;

    assign beat = mon_tvalid & mon_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (arm) begin
            state_d = ST_ARMED;
        end else begin
            case (state_q)
                ST_ARMED: begin
                    if (stop || (trig_fire && post_lat_q == '0)) begin
                        state_d = ST_DONE;
                    end else if (trig_fire) begin
                        state_d = ST_TRIG;
                    end
                end
                ST_TRIG: begin
                    if (stop || (wr_en && post_rem_q == AW'(1))) begin
                        state_d = ST_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // The arm cycle itself never records a beat.
    always_comb begin
        wr_en     = 1'b0;
        trig_fire = 1'b0;
        case (state_q)
            ST_ARMED: begin
                wr_en     = (|beat) && !arm;
                trig_fire = wr_en && (|(beat & trig_mask));
            end
            ST_TRIG: wr_en = (|beat) && !arm;
            default: ;
        endcase
    end

    always_comb begin
        wr_entry = '0;
        wr_entry[TSL +: TS_WIDTH] = ts_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (beat[i]) begin
                wr_entry[i*SW + BEAT_OFS] = 1'b1;
                wr_entry[i*SW + LAST_OFS] = mon_tlast[i];
                wr_entry[i*SW + SLOT_DATA_OFS +: DATA_WIDTH] = mon_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // post_count's width already bounds it to DEPTH-1, so the trigger entry survives.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        trig_ptr_d = trig_ptr_q;
        post_lat_d = post_lat_q;
        post_rem_d = post_rem_q;
        entries_d  = entries_q;
        ts_d       = ts_q + 1'b1;
        if (arm) begin
            wr_ptr_d   = '0;
            entries_d  = '0;
            ts_d       = '0;
            post_lat_d = post_count;
        end else if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (entries_q != ENT_MAX) begin
                entries_d = entries_q + 1'b1;
            end
            if (trig_fire) begin
                trig_ptr_d = wr_ptr_q;
                post_rem_d = post_lat_q;
            end else if (state_q == ST_TRIG) begin
                post_rem_d = post_rem_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            trig_ptr_q <= '0;
            post_lat_q <= '0;
            post_rem_q <= '0;
            entries_q  <= '0;
            ts_q       <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            trig_ptr_q <= trig_ptr_d;
            post_lat_q <= post_lat_d;
            post_rem_q <= post_rem_d;
            entries_q  <= entries_d;
            ts_q       <= ts_d;
        end
    end

    usb_trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_entry),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign state    = state_q;
    assign wr_ptr   = wr_ptr_q;
    assign trig_ptr = trig_ptr_q;
    assign entries  = entries_q;

endmodule

// File: tb/tb_usb_stream_trace.sv
// Bench for usb_stream_trace: directed scenarios plus random traffic against a behavioural model.
module tb_usb_stream_trace;

    localparam int CH  = 2;
    localparam int DW  = 8;
    localparam int DEP = 16;
    localparam int TSW = 16;
    localparam int AW  = 4;
    localparam int SLW = DW + 2;
    localparam int EW  = TSW + CH*SLW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [CH-1:0]     mon_tvalid = '0;
    logic [CH-1:0]     mon_tready = '0;
    logic [CH-1:0]     mon_tlast = '0;
    logic [CH*DW-1:0]  mon_tdata = '0;
    logic              arm = 1'b0;
    logic              stop = 1'b0;
    logic [CH-1:0]     trig_mask = '0;
    logic [AW-1:0]     post_count = '0;
    logic              rd_en = 1'b0;
    logic [AW-1:0]     rd_addr = '0;
    logic [EW-1:0]     rd_data;
    logic [1:0]        state;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     trig_ptr;
    logic [AW:0]       entries;

    int total = 0;
    int bad = 0;
    bit chk_on = 1'b0;

    usb_stream_trace #(
        .CHANNELS   (CH),
        .DATA_WIDTH (DW),
        .DEPTH      (DEP),
        .TS_WIDTH   (TSW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mon_tvalid (mon_tvalid),
        .mon_tready (mon_tready),
        .mon_tlast  (mon_tlast),
        .mon_tdata  (mon_tdata),
        .arm        (arm),
        .stop       (stop),
        .trig_mask  (trig_mask),
        .post_count (post_count),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .state      (state),
        .wr_ptr     (wr_ptr),
        .trig_ptr   (trig_ptr),
        .entries    (entries)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: capture state as plain integers, trace memory as an array with known flags.
    int            m_state, m_wp, m_trig, m_cnt, m_ts, m_post, m_left;
    logic [EW-1:0] m_mem [DEP];
    bit            m_known [DEP];
    logic [EW-1:0] m_rd;
    bit            m_rd_ok;

    function automatic logic [EW-1:0] mk_entry(input int ts, input logic [CH-1:0] b,
                                               input logic [CH-1:0] l, input logic [CH*DW-1:0] d);
        logic [EW-1:0] e;
        e = EW'(ts) << (CH*SLW);
        for (int c = 0; c < CH; c++) begin
            if (b[c]) e = e | (EW'({1'b1, l[c], d[c*DW +: DW]}) << (c*SLW));
        end
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        logic [CH-1:0] b;
        bit capturing;
        if (!rst_n) begin
            m_state = 0; m_wp = 0; m_trig = 0; m_cnt = 0; m_ts = 0; m_post = 0; m_left = 0;
            m_rd = '0; m_rd_ok = 1'b1;
            for (int i = 0; i < DEP; i++) m_known[i] = 1'b0;
        end else begin
            b = mon_tvalid & mon_tready;
            if (rd_en) begin
                m_rd_ok = m_known[rd_addr];
                m_rd    = m_mem[rd_addr];
            end
            if (arm) begin
                m_state = 1; m_wp = 0; m_cnt = 0; m_ts = 0; m_post = int'(post_count);
            end else begin
                capturing = (m_state == 1 || m_state == 2);
                if (capturing && b != 0) begin
                    m_mem[m_wp]   = mk_entry(m_ts, b, mon_tlast, mon_tdata);
                    m_known[m_wp] = 1'b1;
                    if (m_state == 1 && (b & trig_mask) != 0) begin
                        m_trig = m_wp;
                        if (m_post == 0) m_state = 3;
                        else begin m_state = 2; m_left = m_post; end
                    end else if (m_state == 2) begin
                        m_left = m_left - 1;
                        if (m_left == 0) m_state = 3;
                    end
                    m_wp = (m_wp + 1) % DEP;
                    if (m_cnt < DEP) m_cnt = m_cnt + 1;
                end
                if (stop && capturing) m_state = 3;
                m_ts = (m_ts + 1) % (1 << TSW);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && chk_on) begin
            chk("state", 64'(state), 64'(m_state));
            chk("wr_ptr", 64'(wr_ptr), 64'(m_wp));
            chk("trig_ptr", 64'(trig_ptr), 64'(m_trig));
            chk("entries", 64'(entries), 64'(m_cnt));
            if (m_rd_ok) chk("rd_data", 64'(rd_data), 64'(m_rd));
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_in();
        mon_tvalid = '0; mon_tready = '0; mon_tlast = '0; mon_tdata = '0;
        arm = 1'b0; stop = 1'b0; rd_en = 1'b0;
    endtask

    task automatic do_arm(input logic [CH-1:0] mask, input logic [AW-1:0] post);
        arm = 1'b1; trig_mask = mask; post_count = post;
        tick();
        arm = 1'b0;
    endtask

    task automatic beat(input logic [CH-1:0] v, input logic [CH-1:0] l, input logic [CH*DW-1:0] d);
        mon_tvalid = v; mon_tready = v; mon_tlast = l; mon_tdata = d;
        tick();
        clear_in();
    endtask

    task automatic read_at(input logic [AW-1:0] a);
        rd_en = 1'b1; rd_addr = a;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        #3;
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_wr_ptr", 64'(wr_ptr), 64'd0);
        chk("rst_entries", 64'(entries), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk_on = 1'b1;

        // Single beat: trigger with post_count 0 after three idle cycles.
        do_arm(2'b01, 4'd0);
        repeat (3) tick();
        beat(2'b01, 2'b01, 16'h00A5);
        chk("s1_state", 64'(state), 64'd3);
        chk("s1_entries", 64'(entries), 64'd1);
        chk("s1_trig_ptr", 64'(trig_ptr), 64'd0);
        read_at(4'd0);
        chk("s1_entry0", 64'(rd_data), 64'h3003A5);
        tick();
        chk("s1_rd_hold", 64'(rd_data), 64'h3003A5);

        // Simultaneous beats on both channels share one entry.
        do_arm(2'b00, 4'd0);
        beat(2'b11, 2'b00, 16'h2211);
        read_at(4'd0);
        chk("s2_both", 64'(rd_data), 64'h88A11);
        chk("s2_entries", 64'(entries), 64'd1);

        // Pre-trigger wrap.
        do_arm(2'b01, 4'd3);
        repeat (20) beat(2'b10, 2'($urandom), 16'($urandom));
        beat(2'b01, 2'b00, 16'h005A);
        repeat (3) beat(2'b10, 2'b10, 16'($urandom));
        chk("s3_entries", 64'(entries), 64'd16);
        chk("s3_trig_ptr", 64'(trig_ptr), 64'd4);
        chk("s3_wr_ptr", 64'(wr_ptr), 64'd8);
        chk("s3_state", 64'(state), 64'd3);
        read_at(4'd4);

        // Back-pressure: only the completed handshake is logged.
        do_arm(2'b00, 4'd5);
        mon_tvalid = 2'b01; mon_tdata = 16'h0033;
        repeat (5) tick();
        mon_tready = 2'b01;
        tick();
        clear_in();
        tick();
        chk("s4_entries", 64'(entries), 64'd1);
        chk("s4_state", 64'(state), 64'd1);

        // arm and stop together: arm wins.
        arm = 1'b1; stop = 1'b1; trig_mask = 2'b01; post_count = 4'd5;
        tick();
        clear_in();
        chk("s5_state", 64'(state), 64'd1);
        chk("s5_entries", 64'(entries), 64'd0);
        chk("s5_wr_ptr", 64'(wr_ptr), 64'd0);

        // stop in TRIGGERED: same-cycle beat still written, then frozen.
        beat(2'b01, 2'b00, 16'h0001);
        chk("s5_trig", 64'(state), 64'd2);
        beat(2'b10, 2'b00, 16'h0200);
        stop = 1'b1;
        beat(2'b10, 2'b10, 16'h0300);
        chk("s5_stop_entries", 64'(entries), 64'd3);
        repeat (3) beat(2'b01, 2'b01, 16'h0044);
        chk("s5_frozen", 64'(entries), 64'd3);
        chk("s5_done", 64'(state), 64'd3);

        // Asynchronous reset while TRIGGERED.
        do_arm(2'b01, 4'd5);
        beat(2'b01, 2'b00, 16'h0011);
        beat(2'b10, 2'b00, 16'h2200);
        chk("s6_trig", 64'(state), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_rst_state", 64'(state), 64'd0);
        chk("s6_rst_wr_ptr", 64'(wr_ptr), 64'd0);
        chk("s6_rst_entries", 64'(entries), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("s6_rd_zero", 64'(rd_data), 64'd0);

        // Random traffic.
        repeat (1500) begin
            mon_tvalid = 2'($urandom);
            mon_tready = 2'($urandom);
            mon_tlast  = 2'($urandom);
            mon_tdata  = 16'($urandom);
            arm        = ($urandom_range(0, 59) == 0);
            stop       = ($urandom_range(0, 79) == 0);
            trig_mask  = 2'($urandom);
            post_count = 4'($urandom);
            rd_en      = 1'($urandom);
            rd_addr    = 4'($urandom);
            tick();
        end
        clear_in();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
